uart_tx: RTL



---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_bit_timer.sv | 46 ++++
 rtl/uart_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants used by both the transmit and receive paths.
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 8;
  localparam logic [3:0]  STATE_IDLE    = 4'd0;

  typedef enum logic [1:0] {
    NO_PARITY   = 2'd0,
    ODD_PARITY  = 2'd1,
    EVEN_PARITY = 2'd2
  } parity_t;

  typedef enum logic [3:0] {
    TX_IDLE   = STATE_IDLE,
    TX_START  = 4'd1,
    TX_DATA   = 4'd2,
    TX_PARITY = 4'd3,
    TX_STOP   = 4'd4
  } tx_state_t;

  function automatic logic [3:0] clamp_data_width(input logic [3:0] w);
    if (w == 4'd0 || w > 4'(MAX_DATA_BITS)) begin
      return 4'(MAX_DATA_BITS);
    end else begin
      return w;
    end
  endfunction

  function automatic logic [1:0] clamp_stop_bits(input logic [1:0] s);
    return (s == 2'd0) ? 2'd1 : s;
  endfunction

  // The unused encoding 3 behaves as no parity.
  function automatic parity_t norm_parity(input parity_t p);
    return (p == ODD_PARITY || p == EVEN_PARITY) ? p : NO_PARITY;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loads a period, then flags the last clock of every
// period and auto-reloads so consecutive bits follow without gaps.
module uart_bit_timer #(
  parameter int SAMPLE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [SAMPLE_WIDTH-1:0] period,
  output logic                    bit_end,
  output logic                    bit_end_next
);

  logic [SAMPLE_WIDTH-1:0] r_period;
  logic [SAMPLE_WIDTH-1:0] r_count;

  // Period latch and down-counter with reload on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= '0;
      r_count  <= '0;
    end else if (load) begin
      r_period <= period;
      r_count  <= period;
    end else if (r_count == '0) begin
      r_count <= r_period;
    end else begin
      r_count <= r_count - SAMPLE_WIDTH'(1);
    end
  end

  assign bit_end = (r_count == '0);

  // Lookahead: will the clock after this edge be the last clock of its bit.
  always_comb begin
    bit_end_next = 1'b0;
    if (load) begin
      bit_end_next = (period == '0);
    end else if (r_count == '0) begin
      bit_end_next = (r_period == '0);
    end else begin
      bit_end_next = (r_count == SAMPLE_WIDTH'(1));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, runtime-configurable
// bit period, data width, parity and stop bits, all latched at acceptance.
module uart_tx
  import uart_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
  input  logic [3:0]              data_width,
  input  logic [1:0]              stop_bits,
  input  parity_t                 parity,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    tx_done,
  output logic                    tx_out,
  output logic [3:0]              state_o
);

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic [3:0] r_width;
  logic [1:0] r_stops;
  logic [1:0] r_stop_cnt;
  parity_t    r_parity;
  logic       r_par_acc;
  logic       r_tx_out;
  logic       r_tx_done;

  logic w_accept;
  logic w_bit_end;
  logic w_bit_end_next;
  logic w_data_last;
  logic w_par_en;
  logic w_final_stop_next;
  logic w_done_next;

  assign tx_ready    = (r_state == TX_IDLE) & enable & ~reset;
  assign w_accept    = tx_valid & tx_ready;
  assign w_data_last = (r_bit_cnt == r_width);
  assign w_par_en    = (r_parity != NO_PARITY);
  assign w_done_next = w_final_stop_next & w_bit_end_next;

  assign tx_out  = r_tx_out;
  assign tx_done = r_tx_done;
  assign state_o = r_state;

  uart_bit_timer #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_bit_timer (
    .clk          (clk),
    .reset        (reset),
    .load         (w_accept),
    .period       (samples_per_bit),
    .bit_end      (w_bit_end),
    .bit_end_next (w_bit_end_next)
  );

  // Is the clock after this edge inside the final stop bit (drives the registered done).
  always_comb begin
    w_final_stop_next = 1'b0;
    case (r_state)
      TX_DATA:   w_final_stop_next = w_bit_end & w_data_last & ~w_par_en & (r_stops == 2'd1);
      TX_PARITY: w_final_stop_next = w_bit_end & (r_stops == 2'd1);
      TX_STOP: begin
        if (w_bit_end) begin
          w_final_stop_next = (({1'b0, r_stop_cnt} + 3'd1) == {1'b0, r_stops});
        end else begin
          w_final_stop_next = (r_stop_cnt == r_stops);
        end
      end
      default:   w_final_stop_next = 1'b0;
    endcase
  end

  // Frame FSM with shift register, bit/stop counters and parity accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= TX_IDLE;
      r_shift    <= 8'd0;
      r_bit_cnt  <= 4'd0;
      r_width    <= 4'd8;
      r_stops    <= 2'd1;
      r_stop_cnt <= 2'd0;
      r_parity   <= NO_PARITY;
      r_par_acc  <= 1'b0;
      r_tx_out   <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= w_done_next;
      case (r_state)
        TX_IDLE: begin
          r_tx_out <= 1'b1;
          if (w_accept) begin
            r_state    <= TX_START;
            r_tx_out   <= 1'b0;
            r_shift    <= tx_data;
            r_width    <= clamp_data_width(data_width);
            r_stops    <= clamp_stop_bits(stop_bits);
            r_parity   <= norm_parity(parity);
            r_par_acc  <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_stop_cnt <= 2'd0;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_state   <= TX_DATA;
            r_tx_out  <= r_shift[0];
            r_par_acc <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= 4'd1;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            if (w_data_last && w_par_en) begin
              r_state  <= TX_PARITY;
              r_tx_out <= (r_parity == ODD_PARITY) ? ~r_par_acc : r_par_acc;
            end else if (w_data_last) begin
              r_state    <= TX_STOP;
              r_tx_out   <= 1'b1;
              r_stop_cnt <= 2'd1;
            end else begin
              r_tx_out  <= r_shift[0];
              r_par_acc <= r_par_acc ^ r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        TX_PARITY: begin
          if (w_bit_end) begin
            r_state    <= TX_STOP;
            r_tx_out   <= 1'b1;
            r_stop_cnt <= 2'd1;
          end
        end
        TX_STOP: begin
          r_tx_out <= 1'b1;
          if (w_bit_end) begin
            if (r_stop_cnt == r_stops) begin
              r_state <= TX_IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + 2'd1;
            end
          end
        end
        default: begin
          r_state  <= TX_IDLE;
          r_tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
